// File: rtl/mpu_pkg.sv
// Shared types, default dimensions and helpers for the MPU load/store controller.
// The bus widths below describe a 4x4 single-precision matrix register file.
package mpu_pkg;

   localparam int DEF_M               = 4;
   localparam int DEF_N               = 4;
   localparam int DEF_FPBITS          = 31;
   localparam int DEF_MBITS           = 2;
   localparam int DEF_NBITS           = 2;
   localparam int DEF_MATRIX_REG_BITS = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_ERR,
      ST_RELEASE
   } ldst_state_t;

   typedef enum logic {
      GRANT_LOAD,
      GRANT_STORE
   } ldst_grant_t;

   function automatic logic load_size_bad(input int m, input int n,
                                          input int m_max, input int n_max);
      return (m == 0) || (n == 0) || (m > m_max) || (n > n_max);
   endfunction

endpackage

// File: rtl/mpu_ij_counter.sv
// Row-major (i, j) element walker shared by load and store streams.
// Column index j wraps at n and bumps row i; last flags the final element of m*n.
module mpu_ij_counter #(
   parameter int MW = 3,
   parameter int NW = 3,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          en,
   input  logic [MW-1:0] m,
   input  logic [NW-1:0] n,
   output logic [MW-1:0] i,
   output logic [NW-1:0] j,
   output logic          last
);

   logic [CW-1:0] cnt;
   logic [CW-1:0] total;

   assign total = CW'(m) * CW'(n);
   assign last  = en && (cnt == total - CW'(1));

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         cnt <= '0;
         i   <= '0;
         j   <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
         if (j == n - NW'(1)) begin
            j <= '0;
            i <= i + MW'(1);
         end else begin
            j <= j + NW'(1);
         end
      end
   end

endmodule

// File: rtl/mpu_ldst_ctrl.sv
// Load/store streaming controller between memory and the matrix register file.
// Define MPU_LDST_RR_EN to alternate grants on simultaneous requests (else load wins).
module mpu_ldst_ctrl
   import mpu_pkg::*;
#(
   parameter int M               = DEF_M,
   parameter int N               = DEF_N,
   parameter int FPBITS          = DEF_FPBITS,
   parameter int MBITS           = DEF_MBITS,
   parameter int NBITS           = DEF_NBITS,
   parameter int MATRIX_REG_BITS = DEF_MATRIX_REG_BITS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en,
   input  logic                       store_en,
   input  logic [MATRIX_REG_BITS:0]   mem_load_addr,
   input  logic [MATRIX_REG_BITS:0]   mem_store_addr,
   input  logic [MBITS:0]             mem_m_load_size,
   input  logic [NBITS:0]             mem_n_load_size,
   input  logic [FPBITS:0]            mem_load_element,
   output logic                       mem_load_ack,
   output logic                       mem_load_error,
   output logic                       mem_store_en,
   output logic [FPBITS:0]            mem_store_element,
   output logic [MBITS:0]             mem_m_store_size,
   output logic [NBITS:0]             mem_n_store_size,
   output logic                       reg_load_en,
   output logic [MATRIX_REG_BITS:0]   reg_load_addr,
   output logic [FPBITS:0]            reg_load_element,
   output logic [MBITS:0]             reg_i_load_loc,
   output logic [NBITS:0]             reg_j_load_loc,
   output logic [MBITS:0]             reg_m_load_size,
   output logic [NBITS:0]             reg_n_load_size,
   output logic                       reg_store_en,
   output logic [MATRIX_REG_BITS:0]   reg_store_addr,
   output logic [MBITS:0]             reg_i_store_loc,
   output logic [NBITS:0]             reg_j_store_loc,
   input  logic [FPBITS:0]            reg_store_element,
   input  logic [MBITS:0]             reg_m_store_size,
   input  logic [NBITS:0]             reg_n_store_size
);

   localparam int CW = $clog2(M * N) + 1;

   ldst_state_t state, next_state;
   ldst_grant_t last_grant;
   logic        grant_load, grant_store;
   logic        load_bad, store_empty;
   logic        ctr_en, ctr_last;
   logic [MBITS:0] ctr_i, m_bound;
   logic [NBITS:0] ctr_j, n_bound;

   assign load_bad    = load_size_bad(int'(mem_m_load_size), int'(mem_n_load_size), M, N);
   assign store_empty = (reg_m_store_size == '0) || (reg_n_store_size == '0);

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   // NOTE: every output is defaulted first so no path through the case infers a latch.
   always_comb begin
      next_state     = state;
      grant_load     = 1'b0;
      grant_store    = 1'b0;
      mem_load_ack   = 1'b0;
      mem_load_error = 1'b0;
      reg_store_en   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (load_en && store_en) begin
`ifdef MPU_LDST_RR_EN
               grant_load = (last_grant == GRANT_STORE);
`else
               grant_load = 1'b1;
`endif
               grant_store = !grant_load;
            end else begin
               grant_load  = load_en;
               grant_store = store_en;
            end
            if (grant_load)       next_state = load_bad    ? ST_ERR     : ST_LOAD;
            else if (grant_store) next_state = store_empty ? ST_RELEASE : ST_STORE;
         end
         ST_LOAD: begin
            mem_load_ack = 1'b1;
            if (ctr_last) next_state = ST_RELEASE;
         end
         ST_STORE: begin
            reg_store_en = 1'b1;
            if (ctr_last) next_state = ST_RELEASE;
         end
         ST_ERR: begin
            mem_load_error = 1'b1;
            next_state     = ST_RELEASE;
         end
         ST_RELEASE: begin
            // The requester must drop the enable it was granted before anything new starts.
            if (last_grant == GRANT_LOAD ? !load_en : !store_en) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign ctr_en  = mem_load_ack | reg_store_en;
   assign m_bound = (state == ST_STORE) ? mem_m_store_size : reg_m_load_size;
   assign n_bound = (state == ST_STORE) ? mem_n_store_size : reg_n_load_size;

   mpu_ij_counter #(
      .MW(MBITS + 1),
      .NW(NBITS + 1),
      .CW(CW)
   ) u_ij_counter (
      .clk  (clk),
      .rst  (rst),
      .clear(!ctr_en),
      .en   (ctr_en),
      .m    (m_bound),
      .n    (n_bound),
      .i    (ctr_i),
      .j    (ctr_j),
      .last (ctr_last)
   );

   assign reg_i_store_loc   = ctr_i;
   assign reg_j_store_loc   = ctr_j;
   assign mem_store_element = mem_store_en ? reg_store_element : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant       <= GRANT_STORE;
         reg_load_en      <= 1'b0;
         reg_load_addr    <= '0;
         reg_load_element <= '0;
         reg_i_load_loc   <= '0;
         reg_j_load_loc   <= '0;
         reg_m_load_size  <= '0;
         reg_n_load_size  <= '0;
         reg_store_addr   <= '0;
         mem_store_en     <= 1'b0;
         mem_m_store_size <= '0;
         mem_n_store_size <= '0;
      end else begin
         reg_load_en  <= mem_load_ack;
         mem_store_en <= reg_store_en;
         if (mem_load_ack) begin
            reg_load_element <= mem_load_element;
            reg_i_load_loc   <= ctr_i;
            reg_j_load_loc   <= ctr_j;
         end
         if (grant_load) begin
            last_grant      <= GRANT_LOAD;
            reg_load_addr   <= mem_load_addr;
            reg_m_load_size <= mem_m_load_size;
            reg_n_load_size <= mem_n_load_size;
         end
         if (grant_store) begin
            last_grant       <= GRANT_STORE;
            reg_store_addr   <= mem_store_addr;
            mem_m_store_size <= reg_m_store_size;
            mem_n_store_size <= reg_n_store_size;
         end
      end
   end

endmodule
